// File: rtl/sa_vc_scheduler_pkg.sv
// Shared router constants and types for the input-port switch-allocation
// scheduler and its helpers.
package sa_vc_scheduler_pkg;

    // Router geometry: five ports (local plus four mesh directions).
    localparam int SA_NPORTS    = 5;
    localparam int SA_V_DEFAULT = 4;

    // Output-port indices into the one-hot port vector.
    localparam int PORT_LOCAL = 0;
    localparam int PORT_NORTH = 1;
    localparam int PORT_EAST  = 2;
    localparam int PORT_SOUTH = 3;
    localparam int PORT_WEST  = 4;

    // Wormhole lock state of one input port.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } sa_state_t;

endpackage

// File: rtl/sa_vc_scheduler_if.sv
// Bundle between the VC buffers / main switch allocator and one input
// port's stage-1 scheduler. The scheduler uses the slave view.
interface sa_vc_scheduler_if
    import sa_vc_scheduler_pkg::*;
#(
    parameter int V = SA_V_DEFAULT,
    parameter int N = SA_NPORTS
);
    logic [V-1:0]   vc_valid;
    logic [V-1:0]   vc_credit_ok;
    logic [V-1:0]   vc_tail;
    logic [V*N-1:0] vc_outport;
    logic [N-1:0]   reqSA_to_main;
    logic           inputGrantSA;
    logic [V-1:0]   vc_grant;
    logic           lock_active;
    logic           sa_err;

    modport master (
        output vc_valid, vc_credit_ok, vc_tail, vc_outport, inputGrantSA,
        input  reqSA_to_main, vc_grant, lock_active, sa_err
    );

    modport slave (
        input  vc_valid, vc_credit_ok, vc_tail, vc_outport, inputGrantSA,
        output reqSA_to_main, vc_grant, lock_active, sa_err
    );
endinterface

// File: rtl/sa_vc_scheduler_rr_pick.sv
// Combinational rotating-priority picker: returns the first requester at or
// after the pointer (wrapping modulo V) as one-hot plus its index.
module sa_vc_scheduler_rr_pick #(
    parameter int V  = 4,
    parameter int PW = (V > 1) ? $clog2(V) : 1
) (
    input  logic [V-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [V-1:0]  o_gnt,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);
    localparam int SW = PW + 1;

    // Scan ptr, ptr+1, ... modulo V and keep the first requester found.
    always_comb begin
        logic [SW-1:0] w_sum;
        logic [PW-1:0] w_j;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_sum = '0;
        w_j   = '0;
        for (int k = 0; k < V; k++) begin
            w_sum = {1'b0, i_ptr} + SW'(k);
            if (w_sum >= SW'(V)) begin
                w_sum = w_sum - SW'(V);
            end
            w_j = w_sum[PW-1:0];
            if (!o_any && i_req[w_j]) begin
                o_any      = 1'b1;
                o_gnt[w_j] = 1'b1;
                o_idx      = w_j;
            end
        end
    end
endmodule

// File: rtl/sa_vc_scheduler.sv
// Stage-1 switch-allocation scheduler for one router input port: picks one
// eligible VC per cycle by round robin, forwards its output-port request to
// the main allocator, and turns the returned port grant into a VC read strobe.
// With LOCK=1 the port stays on one VC from head flit to tail flit.
module sa_vc_scheduler
    import sa_vc_scheduler_pkg::*;
#(
    parameter int V    = SA_V_DEFAULT,
    parameter int N    = SA_NPORTS,
    parameter int LOCK = 0
) (
    input  logic                 clk,
    input  logic                 rstn,
    sa_vc_scheduler_if.slave     io_sa
);
    localparam int PW = (V > 1) ? $clog2(V) : 1;

    function automatic logic is_onehot(input logic [N-1:0] v);
        return (v != '0) && ((v & (v - N'(1))) == '0);
    endfunction

    sa_state_t     r_state;
    logic [PW-1:0] r_lock_vc;
    logic          r_lock_active;
    logic [PW-1:0] r_rr_ptr;
    logic          r_sa_err;

    logic [V-1:0]  w_elig;
    logic [V-1:0]  w_win_oh;
    logic [PW-1:0] w_win_idx;
    logic          w_any;
    logic [N-1:0]  w_win_port;
    logic          w_win_tail;
    logic          w_eff_grant;

    // A VC competes when it has a flit and credit; while locked only the
    // owning VC may compete.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < V; i++) begin
            w_elig[i] = io_sa.vc_valid[i] & io_sa.vc_credit_ok[i] &
                        ((r_state == IDLE) || (r_lock_vc == PW'(i)));
        end
    end

    sa_vc_scheduler_rr_pick #(
        .V  (V),
        .PW (PW)
    ) u_pick (
        .i_req (w_elig),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_win_oh),
        .o_idx (w_win_idx),
        .o_any (w_any)
    );

    // Select the winner's output-port vector and tail flag by its one-hot.
    always_comb begin
        w_win_port = '0;
        for (int i = 0; i < V; i++) begin
            if (w_win_oh[i]) begin
                w_win_port = w_win_port | io_sa.vc_outport[i*N +: N];
            end
        end
        w_win_tail = |(io_sa.vc_tail & w_win_oh);
    end

    // Request and grant are purely combinational so the main allocator can
    // answer in the same cycle; the grant never loops back into the request.
    assign w_eff_grant         = io_sa.inputGrantSA & w_any;
    assign io_sa.reqSA_to_main = (rstn && w_any) ? w_win_port : '0;
    assign io_sa.vc_grant      = (rstn && w_eff_grant) ? w_win_oh : '0;
    assign io_sa.lock_active   = r_lock_active;
    assign io_sa.sa_err        = r_sa_err;

    // Rotate priority past the winner only when the port was actually granted.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rr_ptr <= '0;
        end else if (w_eff_grant) begin
            r_rr_ptr <= (w_win_idx == PW'(V - 1)) ? '0 : (w_win_idx + PW'(1));
        end
    end

    // Wormhole lock: a granted head that is not a tail claims the port until
    // its tail is granted.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state       <= IDLE;
            r_lock_vc     <= '0;
            r_lock_active <= 1'b0;
        end else if ((LOCK != 0) && w_eff_grant) begin
            case (r_state)
                IDLE: begin
                    if (!w_win_tail) begin
                        r_state       <= LOCKED;
                        r_lock_vc     <= w_win_idx;
                        r_lock_active <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (w_win_tail) begin
                        r_state       <= IDLE;
                        r_lock_active <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    r_lock_active <= 1'b0;
                end
            endcase
        end
    end

    // Sticky protocol error: grant with nothing requested, or a malformed
    // output-port vector on the winning VC.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_sa_err <= 1'b0;
        end else if ((io_sa.inputGrantSA && !w_any) ||
                     (w_any && !is_onehot(w_win_port))) begin
            r_sa_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sa_vc_scheduler.sv
// Bench for sa_vc_scheduler: one per-flit instance and one packet-locked
// instance share the VC stimulus; each has its own grant input and its own
// behavioural model.
module tb_sa_vc_scheduler;
    localparam int V = 4;
    localparam int N = 5;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    sa_vc_scheduler_if #(.V(V), .N(N)) bus0 ();
    sa_vc_scheduler_if #(.V(V), .N(N)) bus1 ();

    sa_vc_scheduler #(.V(V), .N(N), .LOCK(0)) dut0 (
        .clk   (clk),
        .rstn  (rstn),
        .io_sa (bus0)
    );

    sa_vc_scheduler #(.V(V), .N(N), .LOCK(1)) dut1 (
        .clk   (clk),
        .rstn  (rstn),
        .io_sa (bus1)
    );

    // Shared stimulus
    logic [V-1:0]   t_valid, t_credit, t_tail;
    logic [V*N-1:0] t_outport;
    bit             t_gnt [2];

    // Model state per instance (instance 1 is the locking one)
    int  m_ptr  [2];
    bit  m_lock [2];
    int  m_lvc  [2];
    bit  m_err  [2];

    // Observations captured on the last step
    logic [N-1:0] o_req [2];
    logic [V-1:0] o_vg  [2];
    logic         o_lk  [2];
    logic         o_err [2];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] port_of(input int i);
        return t_outport[i*N +: N];
    endfunction

    // Spec-level choice: first eligible VC scanning from the pointer.
    task automatic model_pick(input int k, output bit any, output int win);
        any = 0;
        win = 0;
        for (int s = 0; s < V; s++) begin
            int i;
            i = (m_ptr[k] + s) % V;
            if (!any && t_valid[i] && t_credit[i] && (!m_lock[k] || i == m_lvc[k])) begin
                any = 1;
                win = i;
            end
        end
    endtask

    task automatic drive();
        bus0.vc_valid     = t_valid;   bus1.vc_valid     = t_valid;
        bus0.vc_credit_ok = t_credit;  bus1.vc_credit_ok = t_credit;
        bus0.vc_tail      = t_tail;    bus1.vc_tail      = t_tail;
        bus0.vc_outport   = t_outport; bus1.vc_outport   = t_outport;
        bus0.inputGrantSA = t_gnt[0];  bus1.inputGrantSA = t_gnt[1];
    endtask

    // One clock: drive, check at the falling edge, advance the model at the
    // rising edge.
    task automatic step();
        bit any;
        int win;
        logic [N-1:0] exp_req;
        logic [V-1:0] exp_vg;
        drive();
        @(negedge clk);
        o_req[0] = bus0.reqSA_to_main; o_req[1] = bus1.reqSA_to_main;
        o_vg[0]  = bus0.vc_grant;      o_vg[1]  = bus1.vc_grant;
        o_lk[0]  = bus0.lock_active;   o_lk[1]  = bus1.lock_active;
        o_err[0] = bus0.sa_err;        o_err[1] = bus1.sa_err;
        for (int k = 0; k < 2; k++) begin
            model_pick(k, any, win);
            exp_req = (rstn && any) ? port_of(win) : '0;
            exp_vg  = (rstn && any && t_gnt[k]) ? V'(1 << win) : '0;
            check_val($sformatf("req%0d", k), 32'(o_req[k]), 32'(exp_req));
            check_val($sformatf("vcgnt%0d", k), 32'(o_vg[k]), 32'(exp_vg));
            check_val($sformatf("lock%0d", k), 32'(o_lk[k]), 32'(m_lock[k]));
            check_val($sformatf("err%0d", k), 32'(o_err[k]), 32'(m_err[k]));
            if (!rstn) begin
                m_ptr[k] = 0; m_lock[k] = 0; m_lvc[k] = 0; m_err[k] = 0;
            end else begin
                if (t_gnt[k] && !any) m_err[k] = 1;
                if (any && $countones(port_of(win)) != 1) m_err[k] = 1;
                if (t_gnt[k] && any) begin
                    m_ptr[k] = (win + 1) % V;
                    if (k == 1) begin
                        if (!m_lock[k] && !t_tail[win]) begin
                            m_lock[k] = 1;
                            m_lvc[k]  = win;
                        end else if (m_lock[k] && t_tail[win]) begin
                            m_lock[k] = 0;
                        end
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    logic [V-1:0] exp_fair_vg  [5];
    logic [N-1:0] exp_fair_req [5];

    initial begin
        bit any;
        int win;
        logic [N-1:0] p;
        for (int k = 0; k < 2; k++) begin
            m_ptr[k] = 0; m_lock[k] = 0; m_lvc[k] = 0; m_err[k] = 0;
        end
        t_valid   = 4'b1111;
        t_credit  = 4'b1111;
        t_tail    = 4'b1111;
        t_outport = {5'b01000, 5'b00100, 5'b00010, 5'b00001};
        t_gnt[0]  = 1; t_gnt[1] = 1;
        rstn = 1'b0;
        drive();
        @(posedge clk);
        #1;

        // Reset held with all VCs valid and grants asserted
        step();
        check_val("rst_req", 32'(o_req[0]), 32'd0);
        check_val("rst_vg", 32'(o_vg[1]), 32'd0);
        step();
        check_val("rst_err", 32'(o_err[0]), 32'd0);

        // Fairness rotation
        exp_fair_vg  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_fair_req = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b00001};
        rstn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            check_val($sformatf("fair_vg%0d", c), 32'(o_vg[0]), 32'(exp_fair_vg[c]));
            check_val($sformatf("fair_req%0d", c), 32'(o_req[0]), 32'(exp_fair_req[c]));
        end

        // Request without grant holds priority
        t_valid = 4'b0110;
        t_gnt[0] = 0; t_gnt[1] = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            check_val("nog_req", 32'(o_req[0]), 32'b00010);
            check_val("nog_vg", 32'(o_vg[0]), 32'd0);
        end
        t_gnt[0] = 1; t_gnt[1] = 1;
        step();
        check_val("nog_late_vg", 32'(o_vg[0]), 32'b0010);

        // Credit stall skips VC0, then VC0 is served
        t_valid  = 4'b1001;
        t_credit = 4'b1110;
        step();
        check_val("stall_req", 32'(o_req[0]), 32'b01000);
        check_val("stall_vg", 32'(o_vg[0]), 32'b1000);
        t_credit = 4'b1111;
        step();
        check_val("stall_vc0", 32'(o_vg[0]), 32'b0001);

        // Packet lock on VC2 (instance 1)
        t_valid = 4'b0100;
        t_tail  = 4'b0000;
        step();
        check_val("lk_head", 32'(o_vg[1]), 32'b0100);
        t_valid = 4'b0111;
        for (int c = 0; c < 3; c++) begin
            step();
            check_val("lk_active", 32'(o_lk[1]), 32'd1);
            check_val("lk_body", 32'(o_vg[1]), 32'b0100);
        end
        t_credit = 4'b1011;
        t_gnt[1] = 0;
        step();
        check_val("lk_stall_req", 32'(o_req[1]), 32'd0);
        t_credit = 4'b1111;
        t_gnt[1] = 1;
        t_tail   = 4'b0100;
        step();
        check_val("lk_tail", 32'(o_vg[1]), 32'b0100);
        t_valid = 4'b1111;
        t_tail  = 4'b1111;
        step();
        check_val("lk_release", 32'(o_lk[1]), 32'd0);
        check_val("lk_next", 32'(o_vg[1]), 32'b1000);

        // Reset while locked discards the lock
        t_valid = 4'b0001;
        t_tail  = 4'b0000;
        step();
        rstn = 1'b0;
        step();
        check_val("lk_pre_rst", 32'(o_lk[1]), 32'd1);
        rstn = 1'b1;
        t_gnt[0] = 0; t_gnt[1] = 0;
        t_tail = 4'b1111;
        step();
        check_val("lk_rst", 32'(o_lk[1]), 32'd0);

        // Non-one-hot output port sets the error flag
        t_outport[0 +: N] = 5'b00011;
        step();
        step();
        check_val("err_port", 32'(o_err[0]), 32'd1);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        t_outport[0 +: N] = 5'b00001;
        step();
        check_val("err_cleared", 32'(o_err[0]), 32'd0);

        // Grant with no request
        t_valid = 4'b0000;
        t_gnt[0] = 1; t_gnt[1] = 1;
        step();
        check_val("err_gnt_vg", 32'(o_vg[0]), 32'd0);
        t_gnt[0] = 0; t_gnt[1] = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            check_val("err_sticky", 32'(o_err[0]), 32'd1);
        end
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        step();
        check_val("err_rst", 32'(o_err[1]), 32'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            t_valid  = V'($urandom);
            t_credit = V'($urandom) | V'($urandom);
            t_tail   = V'($urandom);
            for (int i = 0; i < V; i++) begin
                p = N'(1) << $urandom_range(0, N - 1);
                t_outport[i*N +: N] = p;
            end
            rstn = ($urandom_range(0, 59) != 0);
            for (int k = 0; k < 2; k++) begin
                model_pick(k, any, win);
                t_gnt[k] = any && ($urandom_range(0, 3) != 0);
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
